pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Consumes the PLL side of the clock generator: drives the PLL RST input and watches its LOCK output.
//  Sequences PLL reset, waits for lock with a timeout and retries, and qualifies lock as stable.
//  Releases a synchronous active-low system reset only after lock is stable; re-asserts it on lock loss.
//  Runs on the PLL reference clock (25 MHz), which is independent of PLL lock.
// PARAMETERS
//  C_sync_stages     2      flip-flop stages synchronising locked_in (min 2)
//  C_pll_rst_cycles  16     clk cycles pll_rst is held high per attempt (min 1)
//  C_lock_timeout    65536  clk cycles allowed in WAIT for lock before a retry (min 2)
//  C_stable_cycles   1024   consecutive locked cycles required before release (min 1)
//  C_max_retries     0      timeouts before FAIL; 0 = retry forever
//  C_cnt_bits        8      width of retry_count and loss_count
// PORTS
//  clk           in   1            25 MHz reference clock
//  rst_n         in   1            asynchronous active-low reset
//  locked_in     in   1            PLL LOCK, asynchronous to clk
//  force_retry   in   1            1-cycle pulse: restart sequence from PLLRST
//  clear_counts  in   1            1-cycle pulse: zero retry_count and loss_count
//  pll_rst       out  1            to PLL RST, active high
//  sys_rst_n     out  1            synchronous active-low reset for clocked logic
//  ready         out  1            high while in RUN
//  fail          out  1            high while in FAIL
//  retry_count   out  C_cnt_bits   lock timeouts since reset/clear, saturating
//  loss_count    out  C_cnt_bits   lock losses in RUN since reset/clear, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): state=PLLRST, cnt=0, pll_rst=1, sys_rst_n=0, ready=0, fail=0, counts=0, sync chain=0.
//  All outputs are registered and decoded from the state register (Moore); no comb path from inputs.
//  lock_s = last stage of the C_sync_stages synchroniser; the FSM uses only lock_s.
//  PLLRST: pll_rst=1; cnt counts 0..C_pll_rst_cycles-1, then ->WAIT with cnt=0.
//  WAIT: pll_rst=0; lock_s=1 -> STABLE with cnt=0; else cnt++; at cnt=C_lock_timeout-1 -> retry_count++ (sat);
//    if C_max_retries!=0 and the new retry_count>=C_max_retries -> FAIL, else -> PLLRST.
//  STABLE: lock_s=0 -> WAIT with cnt=0 (no retry increment); lock_s=1 and cnt=C_stable_cycles-1 -> RUN; else cnt++.
//  RUN: sys_rst_n=1, ready=1; lock_s=0 -> loss_count++ (sat), ->PLLRST (sys_rst_n=0 and ready=0 next cycle).
//  FAIL: pll_rst=0, sys_rst_n=0, ready=0, fail=1; exits only via force_retry or rst_n.
//  Latency: sys_rst_n rises exactly C_sync_stages+C_stable_cycles+1 edges after the first edge sampling locked_in=1
//    (locked_in held high, FSM in WAIT).
//  force_retry: from any state ->PLLRST with cnt=0; retry_count is cleared; loss_count is not incremented.
//    Priority over all other transitions.
//  clear_counts coincident with an increment: the clear wins (result 0).
//  Saturation: counts stop at 2^C_cnt_bits-1; they never wrap.
//  Glitch on lock_s shorter than C_stable_cycles during STABLE: back to WAIT; sys_rst_n stays 0.
//  rst_n assertion mid-sequence: immediate return to reset values, including pll_rst=1.
// TESTING (C_sync_stages=2, C_pll_rst_cycles=4, C_lock_timeout=32, C_stable_cycles=8, C_max_retries=2, C_cnt_bits=4)
//  Lock 10 cycles after pll_rst falls, held -> pll_rst high exactly 4 cycles.
//    sys_rst_n/ready rise 11 edges after locked_in sampled 1; fail=0; counts 0.
//  locked_in never rises -> two pll_rst pulses 4 cycles each, separated by 32 WAIT cycles.
//    Then retry_count=2, fail=1, pll_rst=0, sys_rst_n=0.
//  In RUN, drop locked_in for 1 cycle -> sys_rst_n=0 3 edges later, loss_count=1, pll_rst pulse of 4 cycles.
//    Then re-release after relock.
//  In STABLE, locked_in low for 1 cycle at cnt=5 -> no release.
//    Stable count restarts from 0 on relock; retry_count unchanged.
//  Drive 20 RUN lock losses -> loss_count saturates at 15.
//    clear_counts coincident with a loss -> loss_count=0.
//  In FAIL, pulse force_retry -> PLLRST next cycle, fail=0, retry_count=0.
//    rst_n pulse mid-STABLE -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between the PLL lock supervisor and the clock-generator glue.
// master = supervisor side, slave = PLL/system side.
interface pll_lock_supervisor_if #(
    parameter int unsigned C_cnt_bits = 8
);
    logic                  locked_in;
    logic                  force_retry;
    logic                  clear_counts;
    logic                  pll_rst;
    logic                  sys_rst_n;
    logic                  ready;
    logic                  fail;
    logic [C_cnt_bits-1:0] retry_count;
    logic [C_cnt_bits-1:0] loss_count;

    modport master (
        input  locked_in, force_retry, clear_counts,
        output pll_rst, sys_rst_n, ready, fail, retry_count, loss_count
    );

    modport slave (
        output locked_in, force_retry, clear_counts,
        input  pll_rst, sys_rst_n, ready, fail, retry_count, loss_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, waits for lock with timeout/retry, qualifies lock, then releases sys_rst_n.
// Latency: sys_rst_n rises C_sync_stages+C_stable_cycles+1 edges after locked_in rises (counting the sampling edge).
// No backpressure; all outputs are flops loaded from the next-state decode.
module pll_lock_supervisor #(
    parameter int unsigned C_sync_stages    = 2,
    parameter int unsigned C_pll_rst_cycles = 16,
    parameter int unsigned C_lock_timeout   = 65536,
    parameter int unsigned C_stable_cycles  = 1024,
    parameter int unsigned C_max_retries    = 0,
    parameter int unsigned C_cnt_bits       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pll_lock_supervisor_if.master  bus
);
    localparam int unsigned MAX_A   = (C_pll_rst_cycles > C_lock_timeout) ? C_pll_rst_cycles : C_lock_timeout;
    localparam int unsigned CNT_MAX = (MAX_A > C_stable_cycles) ? MAX_A : C_stable_cycles;
    localparam int          CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0]         RST_LAST  = CW'(C_pll_rst_cycles - 1);
    localparam logic [CW-1:0]         WAIT_LAST = CW'(C_lock_timeout - 1);
    localparam logic [CW-1:0]         STAB_LAST = CW'(C_stable_cycles - 1);
    localparam logic [C_cnt_bits-1:0] CNT_SAT   = '1;

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [C_cnt_bits-1:0] retry_q, retry_nxt, retry_new;
    logic [C_cnt_bits-1:0] loss_q, loss_nxt;
    logic [C_sync_stages-1:0] sync_q;
    logic                  lock_s;
    logic                  pll_rst_q, sys_rst_n_q, ready_q, fail_q;

    assign lock_s = sync_q[C_sync_stages-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state       <= S_PLLRST;
            cnt         <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[C_sync_stages-2:0], bus.locked_in};
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_q     <= retry_nxt;
            loss_q      <= loss_nxt;
            pll_rst_q   <= (state_nxt == S_PLLRST);
            sys_rst_n_q <= (state_nxt == S_RUN);
            ready_q     <= (state_nxt == S_RUN);
            fail_q      <= (state_nxt == S_FAIL);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_q;
        loss_nxt  = loss_q;
        // A clear arriving with a timeout wins, and the fail decision sees the cleared value.
        retry_new = bus.clear_counts ? '0 : ((retry_q == CNT_SAT) ? retry_q : retry_q + 1'b1);

        case (state)
            S_PLLRST: begin
                if (cnt == RST_LAST) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_nxt = S_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == WAIT_LAST) begin
                    retry_nxt = retry_new;
                    cnt_nxt   = '0;
                    if (C_max_retries != 0 && 32'(retry_new) >= C_max_retries) state_nxt = S_FAIL;
                    else                                                       state_nxt = S_PLLRST;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end else if (cnt == STAB_LAST) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    loss_nxt  = (loss_q == CNT_SAT) ? loss_q : loss_q + 1'b1;
                    state_nxt = S_PLLRST;
                    cnt_nxt   = '0;
                end
            end
            S_FAIL: begin
                state_nxt = S_FAIL;
            end
            default: begin
                state_nxt = S_PLLRST;
                cnt_nxt   = '0;
            end
        endcase

        if (bus.clear_counts) begin
            retry_nxt = '0;
            loss_nxt  = '0;
        end

        // Software restart overrides whatever the sequencer decided this cycle.
        if (bus.force_retry) begin
            state_nxt = S_PLLRST;
            cnt_nxt   = '0;
            retry_nxt = '0;
            loss_nxt  = bus.clear_counts ? '0 : loss_q;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_rst_n   = sys_rst_n_q;
    assign bus.ready       = ready_q;
    assign bus.fail        = fail_q;
    assign bus.retry_count = retry_q;
    assign bus.loss_count  = loss_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed segment table, hand sequences and a randomized run
// checked cycle by cycle against a behavioural model of the sequencing rules.
module tb_pll_lock_supervisor;
    localparam int P_RST = 4, T_WAIT = 32, S_STAB = 8, MAXR = 2, CB = 4, SAT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    pll_lock_supervisor_if #(.C_cnt_bits(CB)) bus ();

    pll_lock_supervisor #(
        .C_sync_stages(2), .C_pll_rst_cycles(P_RST), .C_lock_timeout(T_WAIT),
        .C_stable_cycles(S_STAB), .C_max_retries(MAXR), .C_cnt_bits(CB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: a phase name, cycles spent in it, and a 2-deep lock delay line.
    localparam int M_RST = 0, M_WAIT = 1, M_STABLE = 2, M_RUN = 3, M_FAIL = 4;
    int m_phase, m_age, m_retry, m_loss;
    bit m_hist[$];

    function automatic int sat_inc(input int v);
        return (v + 1 > SAT) ? SAT : v + 1;
    endfunction

    task automatic model_reset();
        m_phase = M_RST; m_age = 0; m_retry = 0; m_loss = 0;
        m_hist = {1'b0, 1'b0};
    endtask

    task automatic model_step(input bit lk, input bit fr, input bit cc);
        bit ls;
        int r;
        ls = m_hist[0];
        void'(m_hist.pop_front());
        m_hist.push_back(lk);
        if (fr) begin
            m_phase = M_RST; m_age = 0; m_retry = 0;
            if (cc) m_loss = 0;
            return;
        end
        case (m_phase)
            M_RST: begin
                if (m_age + 1 == P_RST) begin m_phase = M_WAIT; m_age = 0; end
                else m_age++;
            end
            M_WAIT: begin
                if (ls) begin m_phase = M_STABLE; m_age = 0; end
                else if (m_age + 1 == T_WAIT) begin
                    r = cc ? 0 : sat_inc(m_retry);
                    m_retry = r; m_age = 0;
                    m_phase = (r >= MAXR) ? M_FAIL : M_RST;
                end else m_age++;
            end
            M_STABLE: begin
                if (!ls) begin m_phase = M_WAIT; m_age = 0; end
                else if (m_age + 1 == S_STAB) begin m_phase = M_RUN; m_age = 0; end
                else m_age++;
            end
            M_RUN: begin
                if (!ls) begin m_loss = sat_inc(m_loss); m_phase = M_RST; m_age = 0; end
            end
            default: ;
        endcase
        if (cc) begin m_retry = 0; m_loss = 0; end
    endtask

    function automatic logic [11:0] dut_vec();
        return {bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fail, bus.retry_count, bus.loss_count};
    endfunction

    function automatic logic [11:0] mk_vec(input bit pll, input bit sys, input bit fl, input int r, input int l);
        logic [3:0] r4, l4;
        r4 = 4'(r);
        l4 = 4'(l);
        return {pll, sys, sys, fl, r4, l4};
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got pll/sys/rdy/fail/retry/loss=%b_%b_%b_%b_%0d_%0d want %b_%b_%b_%b_%0d_%0d",
                     name, $time, act[11], act[10], act[9], act[8], act[7:4], act[3:0],
                     exp[11], exp[10], exp[9], exp[8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic cycle(input bit lk, input bit fr, input bit cc);
        bus.locked_in = lk; bus.force_retry = fr; bus.clear_counts = cc;
        @(posedge clk);
        model_step(lk, fr, cc);
        #1;
        chk("model", dut_vec(), mk_vec(m_phase == M_RST, m_phase == M_RUN, m_phase == M_FAIL, m_retry, m_loss));
        bus.force_retry = 1'b0; bus.clear_counts = 1'b0;
    endtask

    typedef struct {
        bit lk; bit fr; bit cc; int n;
        bit e_pll; bit e_sys; bit e_fail; int e_retry; int e_loss;
        string name;
    } seg_t;
    seg_t tbl[$];

    task automatic add(input string nm, input bit lk, input bit fr, input bit cc, input int n,
                       input bit pll, input bit sys, input bit fl, input int r, input int l);
        seg_t s;
        s.name = nm; s.lk = lk; s.fr = fr; s.cc = cc; s.n = n;
        s.e_pll = pll; s.e_sys = sys; s.e_fail = fl; s.e_retry = r; s.e_loss = l;
        tbl.push_back(s);
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].lk, tbl[i].fr, tbl[i].cc);
            chk(tbl[i].name, dut_vec(),
                mk_vec(tbl[i].e_pll, tbl[i].e_sys, tbl[i].e_fail, tbl[i].e_retry, tbl[i].e_loss));
        end
        tbl.delete();
    endtask

    // Called #1 after an edge: assert rst_n between edges and check outputs without any clock.
    task automatic async_reset(input string name);
        #5 rst_n = 1'b0;
        #1 chk(name, dut_vec(), mk_vec(1'b1, 1'b0, 1'b0, 0, 0));
        model_reset();
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        bit lk_r;
        bus.locked_in = 1'b0; bus.force_retry = 1'b0; bus.clear_counts = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk("reset_state", dut_vec(), mk_vec(1'b1, 1'b0, 1'b0, 0, 0));
        @(negedge clk) rst_n = 1'b1;

        // Bring-up: pll_rst 4 cycles, lock 10 cycles later, release on the 11th edge.
        add("pllrst_hold",  0, 0, 0, 3,  1, 0, 0, 0, 0);
        add("pllrst_fall",  0, 0, 0, 1,  0, 0, 0, 0, 0);
        add("wait_nolock",  0, 0, 0, 9,  0, 0, 0, 0, 0);
        add("lock_10edges", 1, 0, 0, 10, 0, 0, 0, 0, 0);
        add("lock_release", 1, 0, 0, 1,  0, 1, 0, 0, 0);
        // Lock loss in RUN: sys_rst_n drops on the third edge.
        add("loss_edge1",   0, 0, 0, 1,  0, 1, 0, 0, 0);
        add("loss_edge2",   1, 0, 0, 1,  0, 1, 0, 0, 0);
        add("loss_edge3",   1, 0, 0, 1,  1, 0, 0, 0, 1);
        add("loss_pllrst",  1, 0, 0, 3,  1, 0, 0, 0, 1);
        add("loss_wait",    1, 0, 0, 1,  0, 0, 0, 0, 1);
        add("loss_stable",  1, 0, 0, 8,  0, 0, 0, 0, 1);
        add("loss_rerun",   1, 0, 0, 1,  0, 1, 0, 0, 1);
        // Glitch during STABLE restarts qualification.
        add("force_run",    1, 1, 0, 1,  1, 0, 0, 0, 1);
        add("gl_pllrst",    1, 0, 0, 3,  1, 0, 0, 0, 1);
        add("gl_wait",      1, 0, 0, 1,  0, 0, 0, 0, 1);
        add("gl_stable0",   1, 0, 0, 4,  0, 0, 0, 0, 1);
        add("gl_drop",      0, 0, 0, 1,  0, 0, 0, 0, 1);
        add("gl_cnt5",      1, 0, 0, 1,  0, 0, 0, 0, 1);
        add("gl_to_wait",   1, 0, 0, 1,  0, 0, 0, 0, 1);
        add("gl_restable",  1, 0, 0, 1,  0, 0, 0, 0, 1);
        add("gl_no_early",  1, 0, 0, 7,  0, 0, 0, 0, 1);
        add("gl_release",   1, 0, 0, 1,  0, 1, 0, 0, 1);
        run_table();

        // Twenty losses: loss_count saturates at 15.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 15; k++) cycle(1'b1, 1'b0, 1'b0);
            chk("loss_sat", dut_vec(), mk_vec(1'b0, 1'b1, 1'b0, 0, (i + 2 > SAT) ? SAT : i + 2));
        end

        add("clr_edge1",    0, 0, 0, 1,  0, 1, 0, 0, 15);
        add("clr_edge2",    1, 0, 0, 1,  0, 1, 0, 0, 15);
        add("clr_vs_loss",  1, 0, 1, 1,  1, 0, 0, 0, 0);
        add("clr_rerun",    1, 0, 0, 13, 0, 1, 0, 0, 0);
        // No lock at all: two attempts then FAIL.
        add("nl_force",     0, 1, 0, 1,  1, 0, 0, 0, 0);
        add("nl_pllrst1",   0, 0, 0, 3,  1, 0, 0, 0, 0);
        add("nl_wait1",     0, 0, 0, 1,  0, 0, 0, 0, 0);
        add("nl_wait1_end", 0, 0, 0, 31, 0, 0, 0, 0, 0);
        add("nl_retry1",    0, 0, 0, 1,  1, 0, 0, 1, 0);
        add("nl_pllrst2",   0, 0, 0, 3,  1, 0, 0, 1, 0);
        add("nl_wait2",     0, 0, 0, 1,  0, 0, 0, 1, 0);
        add("nl_wait2_end", 0, 0, 0, 31, 0, 0, 0, 1, 0);
        add("nl_fail",      0, 0, 0, 1,  0, 0, 1, 2, 0);
        add("fail_sticky",  0, 0, 0, 5,  0, 0, 1, 2, 0);
        add("fail_force",   0, 1, 0, 1,  1, 0, 0, 0, 0);
        add("pre_rst_rst",  1, 0, 0, 3,  1, 0, 0, 0, 0);
        add("pre_rst_wait", 1, 0, 0, 1,  0, 0, 0, 0, 0);
        add("pre_rst_stab", 1, 0, 0, 4,  0, 0, 0, 0, 0);
        run_table();
        async_reset("async_rst_stable");

        // Randomized run against the model, with occasional async resets.
        lk_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) lk_r = ~lk_r;
            cycle(lk_r, $urandom_range(0, 249) == 0, $urandom_range(0, 149) == 0);
            if ($urandom_range(0, 999) == 0) async_reset("async_rst_rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
